// File: rtl/day6_product_accumulator_if.sv
// Product-stream / result-stream bundle between the multiplier, the
// accumulator and whatever consumes the dot-product results.
// The master side feeds products and consumes results; the slave side is the
// accumulator itself.
interface day6_product_accumulator_if #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 10,
   parameter int CNT_W  = 2
);

   logic              clear;
   logic [PROD_W-1:0] prod_in;
   logic              in_valid;
   logic              in_ready;
   logic [ACC_W-1:0]  sum_out;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  beat_cnt;

   modport master (
      output clear,
      output prod_in,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  sum_out,
      input  out_valid,
      input  beat_cnt
   );

   modport slave (
      input  clear,
      input  prod_in,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output sum_out,
      output out_valid,
      output beat_cnt
   );

endinterface

// File: rtl/day6_product_accumulator.sv
// Accumulate half of the MAC datapath: sums N_TERMS consecutive unsigned
// products from the multiplier into one dot-product result, then holds that
// result on the output port until the consumer takes it.
// Two states: ACCUM gathers products, DONE parks the finished result. While
// parked, no new products are taken, so a result is never overwritten or lost.
module day6_product_accumulator #(
   parameter int PROD_W  = 8,
   parameter int N_TERMS = 4,
   parameter int ACC_W   = PROD_W + $clog2(N_TERMS),
   parameter int CNT_W   = $clog2(N_TERMS)
) (
   input logic                       clk,
   input logic                       reset,
   day6_product_accumulator_if.slave bus
);

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_DONE  = 1'b1;

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_TERMS - 1);

   logic [0:0]       r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_beatCnt;
   logic [ACC_W-1:0] r_sumOut;
   logic             r_outValid;

   logic             w_inReady;
   logic             w_accept;
   logic             w_lastBeat;
   logic [ACC_W-1:0] w_prodExt;
   logic [ACC_W-1:0] w_accNext;

   // Ready depends only on state, clear and reset, never on in_valid, so the
   // upstream multiplier can look at it without forming a combinational loop.
   always_comb begin
      w_inReady  = (r_state == ST_ACCUM) && !bus.clear && !reset;
      w_accept   = bus.in_valid && w_inReady;
      w_lastBeat = (r_beatCnt == LAST_BEAT);
      w_prodExt  = ACC_W'(bus.prod_in);
      w_accNext  = r_acc + w_prodExt;
   end

   // Group sequencing: add accepted products, close the group on the last
   // beat, and park the result in DONE until the consumer handshakes it.
   // sum_out is deliberately left alone on the output handshake so it keeps
   // showing the last result until the next group overwrites it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_ACCUM;
         r_acc      <= '0;
         r_beatCnt  <= '0;
         r_sumOut   <= '0;
         r_outValid <= 1'b0;
      end else if (r_state == ST_ACCUM) begin
         if (bus.clear) begin
            r_acc     <= '0;
            r_beatCnt <= '0;
         end else if (w_accept) begin
            if (w_lastBeat) begin
               r_sumOut   <= w_accNext;
               r_outValid <= 1'b1;
               r_acc      <= '0;
               r_beatCnt  <= '0;
               r_state    <= ST_DONE;
            end else begin
               r_acc     <= w_accNext;
               r_beatCnt <= r_beatCnt + CNT_W'(1);
            end
         end
      end else begin
         if (r_outValid && bus.out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= ST_ACCUM;
         end
      end
   end

   assign bus.in_ready  = w_inReady;
   assign bus.sum_out   = r_sumOut;
   assign bus.out_valid = r_outValid;
   assign bus.beat_cnt  = r_beatCnt;

endmodule
